regx_bank: RTL and testbench
============================

Name: regx_bank

Overview:
- Parametrised Xdata register bank, next generation of the fixed-map XDATA register file.
- Provides:
  - NREG generic R/W registers with per-register reset values and write protection.
  - NDBC debounced status inputs with sticky W1C flags and interrupt enables.
  - A key-unlocked protection window.
- Sits on the same regx_r/regx_w/regx_addr bus as the existing register file. Its address window is decoded upstream.

Parameters:
- AW, 7: address width; NREG+4 <= 2**AW required.
- NREG, 8: number of R/W registers (1..32).
- NDBC, 8: number of debounced status inputs (1..8).
- DBC_CNT, 3: consecutive stable synced samples required to change a debounced output (2..15).
- RST_VAL, {NREG{8'h00}}: reset value vector; byte i resets register i.
- PROT_MASK, {NREG{1'b0}}: bit i=1 makes register i write-protected.
- LOCK_KEY, 8'hA5: unlock key.
- UNLK_T, 16: unlock window length in clk cycles (1..127).
- UNREG_D, 8'hff: read value of unmapped addresses.

Ports:
- clk  in  1  system clock.
- rrstz  in  1  reset, asynchronous, active-low.
- regx_w  in  1  write strobe, already address-hit.
- regx_addr  in  AW  register address.
- regx_wdat  in  8  write data.
- regx_rdat  out  8  read data, valid the cycle after the address.
- di_sts  in  NDBC  asynchronous status inputs.
- upd  in  1  shadow-transfer strike; used only with REGX_SHADOW_EN.
- r_regs  out  8*NREG  R/W register contents; byte i = register i.
- o_dbc  out  NDBC  debounced status.
- irq  out  1  registered interrupt.
- locked  out  1  protection state.
- regx_werr  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Map (offset from regx_addr=0):
  - 0..NREG-1: REGi.
  - NREG: STAT, read-only {pad 0, o_dbc}.
  - NREG+1: STICKY, W1C.
  - NREG+2: IRQEN, R/W, reset 0.
  - NREG+3: LOCK.
  - Others: read UNREG_D; writes ignored, no werr.
- Read path: address registered every clk (no reset needed); regx_rdat decoded combinationally from the registered address. Latency is 1 cycle.
- Write: takes effect at the clk edge where regx_w=1.
  - Writes to STAT raise regx_werr for 1 cycle; data is discarded.
- Reset values:
  - r_regs=RST_VAL.
  - sticky=0, irqen=0, o_dbc=0, irq=0, regx_werr=0.
  - locked=1 if any PROT_MASK bit is set, else 0.
  - Unlock counter=0.
- Debounce, per channel:
  - 2-flop synchroniser (reset 0) feeds a 4-bit counter.
  - When synced != o_dbc, the counter increments. When it reaches DBC_CNT-1 while still differing, o_dbc flips and the counter clears.
  - When synced == o_dbc, the counter clears.
  - Total latency from an input edge is DBC_CNT+2 clk for a stable input.
- Sticky: bit set when o_dbc goes 0->1, detected on the registered o_dbc. A write of 1 clears it. If set and clear land in the same cycle, set wins.
- irq: irq <= |(sticky & irqen). Asserts 1 clk after sticky/irqen becomes nonzero.
- Lock state machine, states LOCKED / OPEN:
  - Writing LOCK_KEY to LOCK enters OPEN (locked=0) and loads cnt=UNLK_T. Rewriting the key while OPEN reloads cnt.
  - In OPEN, cnt decrements each clk. On the cycle cnt reaches 1, the next state is LOCKED.
  - Writing any non-key value to LOCK enters LOCKED immediately.
  - If PROT_MASK==0: locked stays 0 and LOCK writes are ignored.
  - LOCK read value = {locked, cnt[6:0]}.
- Protected write: a write to REGi with PROT_MASK[i]=1 while locked=1 is ignored and pulses regx_werr. A write in the same cycle as the key write sees the old lock state.
- Reset mid-window: returns to LOCKED with cnt=0.

Optional Feature:
- Macro: REGX_SHADOW_EN.
- Defined:
  - Bus writes to REGi go to a shadow byte (reset RST_VAL).
  - On clk with upd=1, all shadows copy to r_regs in the same edge.
  - A write and upd in the same cycle transfers the newly written value.
  - REGi reads return the shadow value.
- Undefined: writes update r_regs directly, reads return r_regs, and upd is ignored.

Test Plan:
- Reset: after rrstz release, read REG0..REG7 -> RST_VAL bytes. STAT=8'h00, IRQEN=8'h00, regx_rdat=8'hff at address 0x7f.
- Write REG2=8'h3C, then read -> 8'h3C on the cycle after the address (shadow build: appears on r_regs only after upd=1).
- di_sts[0] held at 1 -> o_dbc[0]=1 exactly 5 clk later (DBC_CNT=3). Check sticky[0]=1. With IRQEN=8'h01, irq=1 one clk later. W1C write 8'h01 -> sticky and irq clear. A 2-clk glitch produces no o_dbc change.
- PROT_MASK=8'h01, locked: write REG0=8'h55 -> ignored, regx_werr pulses 1 clk. Write LOCK=8'hA5, then REG0=8'h55 -> accepted. After 16 clk, locked=1 and LOCK reads 8'h80.
- LOCK write of 8'h00 while OPEN -> locked=1 next cycle. Asserting rrstz low mid-window -> locked=1, cnt=0.
- Sticky set and W1C in the same cycle -> bit remains 1.

Source files
------------

// File: rtl/regx_bank.sv
// regx_bank: parametrised XDATA register bank.
// NREG generic R/W registers with write protection, NDBC debounced status
// inputs with sticky W1C flags and interrupt enables, and a key-unlocked
// protection window.
// Optional feature macro: REGX_SHADOW_EN (bus writes land in shadow bytes that
// are transferred to r_regs on upd).
module regx_bank #(
  parameter int unsigned        AW        = 7,
  parameter int unsigned        NREG      = 8,
  parameter int unsigned        NDBC      = 8,
  parameter int unsigned        DBC_CNT   = 3,
  parameter logic [8*NREG-1:0]  RST_VAL   = '0,
  parameter logic [NREG-1:0]    PROT_MASK = '0,
  parameter logic [7:0]         LOCK_KEY  = 8'hA5,
  parameter int unsigned        UNLK_T    = 16,
  parameter logic [7:0]         UNREG_D   = 8'hFF
) (
  input  logic                clk,
  input  logic                rrstz,
  input  logic                regx_w,
  input  logic [AW-1:0]       regx_addr,
  input  logic [7:0]          regx_wdat,
  output logic [7:0]          regx_rdat,
  input  logic [NDBC-1:0]     di_sts,
  input  logic                upd,
  output logic [8*NREG-1:0]   r_regs,
  output logic [NDBC-1:0]     o_dbc,
  output logic                irq,
  output logic                locked,
  output logic                regx_werr
);

  localparam logic [AW-1:0] A_STAT   = AW'(NREG);
  localparam logic [AW-1:0] A_STICKY = AW'(NREG + 1);
  localparam logic [AW-1:0] A_IRQEN  = AW'(NREG + 2);
  localparam logic [AW-1:0] A_LOCK   = AW'(NREG + 3);
  localparam logic          HAS_PROT = |PROT_MASK;
  localparam logic [3:0]    DBC_LAST = 4'(DBC_CNT - 1);

  typedef enum logic {LOCKED, OPEN} lock_st_t;

  lock_st_t          r_state, w_state_nxt;
  logic [6:0]        r_cnt, w_cnt_nxt;
  logic [AW-1:0]     r_addr;
  logic [NDBC-1:0]   r_sync1, r_sync2, r_dbc_d, r_sticky, r_irqen;
  logic [NDBC-1:0][3:0] r_dcnt;
  logic [NREG-1:0]   w_reg_hit, w_reg_we;
  logic              w_wr_lock, w_werr;
  logic [NDBC-1:0]   w_rise, w_clr;
  logic [8*NREG-1:0] w_rd_regs;

  assign locked = (r_state == LOCKED);

  // Bus write decode: per-register hit, protection filter and error strobe
  always_comb begin
    w_reg_hit = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_reg_hit[i] = regx_w && (regx_addr == AW'(i));
    end
    w_reg_we  = w_reg_hit & ~(PROT_MASK & {NREG{locked}});
    w_werr    = (regx_w && (regx_addr == A_STAT)) ||
                (|(w_reg_hit & PROT_MASK & {NREG{locked}}));
    w_wr_lock = regx_w && (regx_addr == A_LOCK);
    w_clr     = (regx_w && (regx_addr == A_STICKY)) ? regx_wdat[NDBC-1:0] : '0;
    w_rise    = o_dbc & ~r_dbc_d;
  end

`ifdef REGX_SHADOW_EN
  logic [8*NREG-1:0] r_shadow, w_shadow_nxt;

  // Shadow next value; upd transfers it so a same-cycle write is included
  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (w_reg_we[i]) w_shadow_nxt[8*i +: 8] = regx_wdat;
    end
  end

  // Shadow bytes and live registers
  always_ff @(posedge clk or negedge rrstz) begin
    if (!rrstz) begin
      r_shadow <= RST_VAL;
      r_regs   <= RST_VAL;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (upd) r_regs <= w_shadow_nxt;
    end
  end

  assign w_rd_regs = r_shadow;
`else
  logic [8*NREG-1:0] w_regs_nxt;
  logic              w_unused_upd;

  assign w_unused_upd = upd;

  // Direct register write data
  always_comb begin
    w_regs_nxt = r_regs;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (w_reg_we[i]) w_regs_nxt[8*i +: 8] = regx_wdat;
    end
  end

  // Live registers
  always_ff @(posedge clk or negedge rrstz) begin
    if (!rrstz) r_regs <= RST_VAL;
    else        r_regs <= w_regs_nxt;
  end

  assign w_rd_regs = r_regs;
`endif

  // Read address pipeline register, no reset needed
  always_ff @(posedge clk) begin
    r_addr <= regx_addr;
  end

  // Read data mux on the registered address
  always_comb begin
    regx_rdat = UNREG_D;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (r_addr == AW'(i)) regx_rdat = w_rd_regs[8*i +: 8];
    end
    if (r_addr == A_STAT)   regx_rdat = 8'(o_dbc);
    if (r_addr == A_STICKY) regx_rdat = 8'(r_sticky);
    if (r_addr == A_IRQEN)  regx_rdat = 8'(r_irqen);
    if (r_addr == A_LOCK)   regx_rdat = {locked, r_cnt};
  end

  // Synchroniser and per-channel debounce counters
  always_ff @(posedge clk or negedge rrstz) begin
    if (!rrstz) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_dcnt  <= '0;
      o_dbc   <= '0;
    end else begin
      r_sync1 <= di_sts;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < NDBC; i++) begin
        if (r_sync2[i] == o_dbc[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DBC_LAST) begin
          r_dcnt[i] <= '0;
          o_dbc[i]  <= r_sync2[i];
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 4'd1;
        end
      end
    end
  end

  // Sticky flags (set beats W1C clear), interrupt enables, irq and werr
  always_ff @(posedge clk or negedge rrstz) begin
    if (!rrstz) begin
      r_dbc_d   <= '0;
      r_sticky  <= '0;
      r_irqen   <= '0;
      irq       <= 1'b0;
      regx_werr <= 1'b0;
    end else begin
      r_dbc_d   <= o_dbc;
      r_sticky  <= (r_sticky & ~w_clr) | w_rise;
      if (regx_w && (regx_addr == A_IRQEN)) r_irqen <= regx_wdat[NDBC-1:0];
      irq       <= |(r_sticky & r_irqen);
      regx_werr <= w_werr;
    end
  end

  // Lock state register
  always_ff @(posedge clk or negedge rrstz) begin
    if (!rrstz) begin
      r_state <= HAS_PROT ? LOCKED : OPEN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Lock next state: key opens/reloads, other values relock, window expires at cnt==1
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (HAS_PROT) begin
      if (w_wr_lock) begin
        if (regx_wdat == LOCK_KEY) begin
          w_state_nxt = OPEN;
          w_cnt_nxt   = 7'(UNLK_T);
        end else begin
          w_state_nxt = LOCKED;
          w_cnt_nxt   = '0;
        end
      end else if (r_state == OPEN) begin
        if (r_cnt <= 7'd1) begin
          w_state_nxt = LOCKED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regx_bank.sv
// Self-checking bench for regx_bank: register reset/read/write, protection and
// unlock window, debounce latency, sticky/irq behaviour, unmapped reads.
module tb_regx_bank;

  localparam int unsigned AW   = 7;
  localparam int unsigned NREG = 8;
  localparam int unsigned NDBC = 8;
  localparam logic [63:0] RSTV = 64'h8877_6655_4433_2211;

  localparam logic [6:0] A_STAT   = 7'd8;
  localparam logic [6:0] A_STICKY = 7'd9;
  localparam logic [6:0] A_IRQEN  = 7'd10;
  localparam logic [6:0] A_LOCK   = 7'd11;

  logic            clk = 1'b0;
  logic            rrstz = 1'b0;
  logic            regx_w = 1'b0;
  logic [AW-1:0]   regx_addr = '0;
  logic [7:0]      regx_wdat = '0;
  logic [7:0]      regx_rdat;
  logic [NDBC-1:0] di_sts = '0;
  logic            upd = 1'b0;
  logic [8*NREG-1:0] r_regs_o;
  logic [NDBC-1:0] o_dbc;
  logic            irq, locked, regx_werr;

  always #5 clk = ~clk;

  regx_bank #(
    .AW(AW), .NREG(NREG), .NDBC(NDBC), .DBC_CNT(3),
    .RST_VAL(RSTV), .PROT_MASK(8'h01), .LOCK_KEY(8'hA5),
    .UNLK_T(16), .UNREG_D(8'hFF)
  ) u_dut (
    .clk(clk), .rrstz(rrstz), .regx_w(regx_w), .regx_addr(regx_addr),
    .regx_wdat(regx_wdat), .regx_rdat(regx_rdat), .di_sts(di_sts),
    .upd(upd), .r_regs(r_regs_o), .o_dbc(o_dbc), .irq(irq),
    .locked(locked), .regx_werr(regx_werr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read scoreboard: expectation pushed at issue, popped one cycle later
  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sbq[$];
  exp_t sb_e;
  logic rd_v = 1'b0;
  logic pend = 1'b0;

  always @(negedge clk) begin
    if (pend) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        sb_e = sbq.pop_front();
        check(sb_e.tag, 64'(regx_rdat), 64'(sb_e.exp));
      end
    end
    pend = rd_v;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    regx_w = 1'b1; regx_addr = a; regx_wdat = d;
    @(posedge clk); #2;
    regx_w = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] e, input string tag);
    exp_t x;
    @(posedge clk); #2;
    regx_addr = a; rd_v = 1'b1;
    x.tag = tag; x.exp = e;
    sbq.push_back(x);
    @(posedge clk); #2;
    rd_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rstv;
    rstv = RSTV;

    // Reset state
    tick(3);
    check("rst_locked", 64'(locked), 64'd1);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_werr", 64'(regx_werr), 64'd0);
    check("rst_dbc", 64'(o_dbc), 64'd0);
    check("rst_regs", r_regs_o, rstv);
    rrstz = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) rd(7'(i), rstv[8*i +: 8], $sformatf("rst_reg%0d", i));
    rd(A_STAT, 8'h00, "rst_stat");
    rd(A_STICKY, 8'h00, "rst_sticky");
    rd(A_IRQEN, 8'h00, "rst_irqen");
    rd(A_LOCK, 8'h80, "rst_lock");
    rd(7'h7F, 8'hFF, "unmapped_7f");
    rd(7'd12, 8'hFF, "unmapped_12");

    // Plain register write
    wr(7'd2, 8'h3C);
    check("reg2_werr", 64'(regx_werr), 64'd0);
    rd(7'd2, 8'h3C, "reg2_rd");
`ifdef REGX_SHADOW_EN
    check("reg2_pre_upd", 64'(r_regs_o[23:16]), 64'h33);
    @(posedge clk); #2; upd = 1'b1;
    @(posedge clk); #2; upd = 1'b0;
`endif
    check("reg2_live", 64'(r_regs_o[23:16]), 64'h3C);

    // Write to read-only STAT
    wr(A_STAT, 8'hFF);
    check("stat_werr", 64'(regx_werr), 64'd1);
    tick(1);
    check("stat_werr_pulse", 64'(regx_werr), 64'd0);
    rd(A_STAT, 8'h00, "stat_unchanged");

    // Protected write while locked
    wr(7'd0, 8'h55);
    check("prot_werr", 64'(regx_werr), 64'd1);
    tick(1);
    check("prot_werr_pulse", 64'(regx_werr), 64'd0);
    rd(7'd0, 8'h11, "prot_ignored");

    // Unlock then write
    wr(A_LOCK, 8'hA5);
    check("unlock", 64'(locked), 64'd0);
    rd(A_LOCK, 8'h0E, "lock_cnt_rd");
    wr(7'd0, 8'h55);
    check("open_werr", 64'(regx_werr), 64'd0);
    rd(7'd0, 8'h55, "open_write");

    // Non-key relocks immediately
    wr(A_LOCK, 8'h00);
    check("relock", 64'(locked), 64'd1);
    wr(7'd0, 8'h66);
    check("relock_werr", 64'(regx_werr), 64'd1);
    rd(7'd0, 8'h55, "relock_ignored");

    // Window expiry: 16 clk after key write
    wr(A_LOCK, 8'hA5);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      check($sformatf("win_open_%0d", k), 64'(locked), 64'd0);
    end
    tick(1);
    check("win_expired", 64'(locked), 64'd1);
    rd(A_LOCK, 8'h80, "lock_after_expiry");

    // Reset mid-window
    wr(A_LOCK, 8'hA5);
    tick(3);
    rrstz = 1'b0;
    #1;
    check("midrst_locked", 64'(locked), 64'd1);
    rd(A_LOCK, 8'h80, "midrst_lock_rd");
    check("midrst_regs", r_regs_o, rstv);
    rrstz = 1'b1;
    tick(1);

    // Debounce latency, sticky and irq
    wr(A_IRQEN, 8'h01);
    rd(A_IRQEN, 8'h01, "irqen_rd");
    di_sts[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check($sformatf("dbc_early_%0d", k), 64'(o_dbc[0]), 64'd0);
    end
    tick(1);
    check("dbc_5clk", 64'(o_dbc), 64'h01);
    tick(1);
    check("irq_not_yet", 64'(irq), 64'd0);
    tick(1);
    check("irq_set", 64'(irq), 64'd1);
    rd(A_STICKY, 8'h01, "sticky_set");
    rd(A_STAT, 8'h01, "stat_dbc");
    wr(A_STICKY, 8'h01);
    tick(1);
    check("irq_clr", 64'(irq), 64'd0);
    rd(A_STICKY, 8'h00, "sticky_clr");

    // 2-clk glitch is filtered
    di_sts[1] = 1'b1;
    tick(2);
    di_sts[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("glitch_%0d", k), 64'(o_dbc), 64'h01);
    end

    // Sticky set and W1C clear in the same cycle: set wins
    di_sts[2] = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    wr(A_STICKY, 8'h04);
    check("dbc_ch2", 64'(o_dbc), 64'h05);
    rd(A_STICKY, 8'h04, "sticky_set_wins");
    check("irq_masked", 64'(irq), 64'd0);
    wr(A_STICKY, 8'h04);
    rd(A_STICKY, 8'h00, "sticky_clr2");

    // Falling debounced edge does not set sticky
    di_sts = '0;
    tick(7);
    check("dbc_fall", 64'(o_dbc), 64'h00);
    rd(A_STICKY, 8'h00, "sticky_no_fall");

    tick(3);
    check("sb_drain", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
